// File: rtl/hood_mode_ctrl.sv
// Hood mode scheduler: debounced buttons -> mode FSM, fan level, countdown seconds and a free-running 1 s tick.
// Optional build macro HOOD_LONG_PRESS_EN: power-off requires holding btn_power for LONG_SEC whole seconds.
module hood_mode_ctrl #(
  parameter int CLK_HZ        = 100_000_000,
  parameter int HURRICANE_SEC = 60,
  parameter int CLEAN_SEC     = 180,
  parameter int LONG_SEC      = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_power,
  input  logic       btn_menu,
  input  logic [2:0] btn_lvl,
  input  logic       btn_clean,
  output logic [1:0] mode,
  output logic [1:0] fan_level,
  output logic [7:0] remain_sec,
  output logic       sec_tick
);
  localparam int              TW        = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [TW-1:0]   TICK_LAST = TW'(CLK_HZ - 1);
  localparam logic [7:0]      H_SEC     = 8'(HURRICANE_SEC);
  localparam logic [7:0]      C_SEC     = 8'(CLEAN_SEC);

  if (HURRICANE_SEC > 255 || CLEAN_SEC > 255 || LONG_SEC > 255) begin : g_bad_param
    $error("hood_mode_ctrl: second counts must fit in 8 bits");
  end

  typedef enum logic [2:0] {
    S_OFF, S_SELECT, S_RUN1, S_RUN2, S_HURR, S_EXITW, S_CLEAN
  } state_t;

  typedef enum logic [2:0] {
    EV_NONE, EV_PWR, EV_MENU, EV_CLEAN, EV_L2, EV_L1, EV_L0
  } ev_t;

  function automatic logic [1:0] mode_of(state_t s);
    logic [1:0] m;
    case (s)
      S_OFF:    m = 2'b00;
      S_SELECT: m = 2'b01;
      S_CLEAN:  m = 2'b11;
      default:  m = 2'b10;
    endcase
    return m;
  endfunction

  function automatic logic [1:0] fan_of(state_t s);
    logic [1:0] f;
    case (s)
      S_RUN1:  f = 2'd1;
      S_RUN2:  f = 2'd2;
      S_HURR:  f = 2'd3;
      default: f = 2'd0;
    endcase
    return f;
  endfunction

  function automatic logic timed(state_t s);
    return (s == S_HURR) || (s == S_EXITW) || (s == S_CLEAN);
  endfunction

  function automatic logic [7:0] dec_sat(logic [7:0] v);
    return (v == 8'd0) ? 8'd0 : v - 8'd1;
  endfunction

  state_t        state, state_nx;
  ev_t           ev;
  logic          h_used, h_used_nx;
  logic [7:0]    remain_nx;
  logic [TW-1:0] tick_cnt;
  logic [5:0]    btn_now, btn_p0, edges;
  logic          pwr_e, pwr_evt, long_off;

  // Free-running second tick, independent of state so timed entries keep the current phase
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick_cnt <= '0;
      sec_tick <= 1'b0;
    end else if (tick_cnt == TICK_LAST) begin
      tick_cnt <= '0;
      sec_tick <= 1'b1;
    end else begin
      tick_cnt <= tick_cnt + 1'b1;
      sec_tick <= 1'b0;
    end
  end

  // Bit order: power, menu, clean, lvl[0], lvl[1], lvl[2]
  assign btn_now = {btn_lvl, btn_clean, btn_menu, btn_power};
  assign edges   = btn_now & ~btn_p0;
  assign pwr_e   = edges[0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) btn_p0 <= '0;
    else     btn_p0 <= btn_now;
  end

`ifdef HOOD_LONG_PRESS_EN
  localparam logic [7:0] L_SEC = 8'(LONG_SEC);
  logic       armed;
  logic [7:0] hold_cnt;

  // A hold only counts if it started inside a session, so the power-on press cannot also power off
  assign pwr_evt  = pwr_e && (state == S_OFF);
  assign long_off = (state != S_OFF) && armed && btn_power && sec_tick &&
                    ((hold_cnt + 8'd1) == L_SEC);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      armed    <= 1'b0;
      hold_cnt <= 8'd0;
    end else if (!btn_power || state_nx == S_OFF) begin
      armed    <= 1'b0;
      hold_cnt <= 8'd0;
    end else begin
      if (pwr_e && state != S_OFF) armed <= 1'b1;
      if (armed && sec_tick) hold_cnt <= hold_cnt + 8'd1;
    end
  end
`else
  assign pwr_evt  = pwr_e;
  assign long_off = 1'b0;
`endif

  always_comb begin
    ev = EV_NONE;
    if      (pwr_evt)   ev = EV_PWR;
    else if (edges[1])  ev = EV_MENU;
    else if (edges[2])  ev = EV_CLEAN;
    else if (edges[5])  ev = EV_L2;
    else if (edges[4])  ev = EV_L1;
    else if (edges[3])  ev = EV_L0;
  end

  always_comb begin
    state_nx  = state;
    remain_nx = remain_sec;
    h_used_nx = h_used;
    case (state)
      S_OFF: begin
        if (ev == EV_PWR) begin
          state_nx  = S_SELECT;
          h_used_nx = 1'b0;
        end
      end
      S_SELECT: begin
        case (ev)
          EV_PWR:   state_nx = S_OFF;
          EV_CLEAN: begin
            state_nx  = S_CLEAN;
            remain_nx = C_SEC;
          end
          EV_L2:    if (!h_used) state_nx = S_HURR;
          EV_L1:    state_nx = S_RUN2;
          EV_L0:    state_nx = S_RUN1;
          default:  ;
        endcase
      end
      S_RUN1, S_RUN2: begin
        case (ev)
          EV_PWR:  state_nx = S_OFF;
          EV_MENU: state_nx = S_SELECT;
          EV_L2:   if (!h_used) state_nx = S_HURR;
          EV_L1:   state_nx = S_RUN2;
          EV_L0:   state_nx = S_RUN1;
          default: ;
        endcase
      end
      S_HURR: begin
        if (ev == EV_PWR) begin
          state_nx = S_OFF;
        end else if (ev == EV_MENU) begin
          state_nx  = S_EXITW;
          remain_nx = H_SEC;
        end else if (sec_tick) begin
          remain_nx = dec_sat(remain_sec);
          if (remain_sec <= 8'd1) state_nx = S_RUN2;
        end
      end
      S_EXITW, S_CLEAN: begin
        if (ev == EV_PWR) begin
          state_nx = S_OFF;
        end else if (sec_tick) begin
          remain_nx = dec_sat(remain_sec);
          if (remain_sec <= 8'd1) state_nx = S_SELECT;
        end
      end
      default: state_nx = S_OFF;
    endcase
    if (long_off) state_nx = S_OFF;
    if (state_nx == S_HURR && state != S_HURR) begin
      h_used_nx = 1'b1;
      remain_nx = H_SEC;
    end
    if (!timed(state_nx)) remain_nx = 8'd0;
  end

  // State and display outputs update together on the edge that acts on a button or tick
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_OFF;
      h_used     <= 1'b0;
      remain_sec <= 8'd0;
      mode       <= 2'b00;
      fan_level  <= 2'd0;
    end else begin
      state      <= state_nx;
      h_used     <= h_used_nx;
      remain_sec <= remain_nx;
      mode       <= mode_of(state_nx);
      fan_level  <= fan_of(state_nx);
    end
  end

endmodule

// File: tb/tb_hood_mode_ctrl.sv
// Bench for hood_mode_ctrl: directed session scenarios plus random button traffic against a behavioural model.
module tb_hood_mode_ctrl;
  localparam int CK = 10, HS = 60, CS = 180, LS = 3;
  localparam int M_OFF = 0, M_SEL = 1, M_R1 = 2, M_R2 = 3, M_HURR = 4, M_EXITW = 5, M_CLEAN = 6;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] b;
  logic [1:0] mode, fan_level;
  logic [7:0] remain_sec;
  logic       sec_tick;
  int         checks = 0, errors = 0;

  hood_mode_ctrl #(.CLK_HZ(CK), .HURRICANE_SEC(HS), .CLEAN_SEC(CS), .LONG_SEC(LS)) dut (
    .clk(clk), .rst(rst), .btn_power(b[0]), .btn_menu(b[1]), .btn_lvl(b[5:3]),
    .btn_clean(b[2]), .mode(mode), .fan_level(fan_level), .remain_sec(remain_sec),
    .sec_tick(sec_tick)
  );

  always #5 clk = ~clk;

  int         m_st, m_rem, m_cyc, m_hold;
  bit         m_hused, m_armed;
  logic [5:0] m_prev;

  function automatic int mode_of(int s);
    if (s == M_OFF) return 0;
    if (s == M_SEL) return 1;
    if (s == M_CLEAN) return 3;
    return 2;
  endfunction

  function automatic int fan_of(int s);
    if (s == M_R1) return 1;
    if (s == M_R2) return 2;
    if (s == M_HURR) return 3;
    return 0;
  endfunction

  task automatic model_reset();
    m_st = M_OFF; m_rem = 0; m_cyc = 0; m_hold = 0;
    m_hused = 0; m_armed = 0; m_prev = '0;
  endtask

  // Applies the rules for one clock edge given the button levels present at that edge
  task automatic model_edge();
    logic [5:0] e;
    bit tick, pwr_ok;
    int ns, w;
    e = b & ~m_prev;
    tick = (m_cyc > 0) && (m_cyc % CK == 0);
`ifdef HOOD_LONG_PRESS_EN
    pwr_ok = (m_st == M_OFF);
`else
    pwr_ok = 1'b1;
`endif
    w = -1;
    if (e[0] && pwr_ok) w = 0;
    else if (e[1]) w = 1;
    else if (e[2]) w = 2;
    else if (e[5]) w = 5;
    else if (e[4]) w = 4;
    else if (e[3]) w = 3;
    ns = m_st;
    if (w == 0 && m_st != M_OFF) ns = M_OFF;
    else case (m_st)
      M_OFF: if (w == 0) begin ns = M_SEL; m_hused = 0; end
      M_SEL: begin
        if (w == 2) begin ns = M_CLEAN; m_rem = CS; end
        else if (w == 5 && !m_hused) ns = M_HURR;
        else if (w == 4) ns = M_R2;
        else if (w == 3) ns = M_R1;
      end
      M_R1, M_R2: begin
        if (w == 1) ns = M_SEL;
        else if (w == 5 && !m_hused) ns = M_HURR;
        else if (w == 4) ns = M_R2;
        else if (w == 3) ns = M_R1;
      end
      M_HURR: begin
        if (w == 1) begin ns = M_EXITW; m_rem = HS; end
        else if (tick) begin m_rem--; if (m_rem == 0) ns = M_R2; end
      end
      default: if (tick) begin
        m_rem--;
        if (m_rem == 0) ns = M_SEL;
      end
    endcase
`ifdef HOOD_LONG_PRESS_EN
    if (m_st != M_OFF && m_armed && b[0] && tick && m_hold + 1 >= LS) ns = M_OFF;
    if (!b[0] || ns == M_OFF) begin
      m_armed = 0; m_hold = 0;
    end else begin
      if (m_armed && tick) m_hold++;
      if (e[0] && m_st != M_OFF) m_armed = 1;
    end
`endif
    if (ns == M_HURR && m_st != M_HURR) begin m_hused = 1; m_rem = HS; end
    if (ns != M_HURR && ns != M_EXITW && ns != M_CLEAN) m_rem = 0;
    m_st = ns;
    m_prev = b;
    m_cyc++;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic cyc1();
    @(posedge clk);
    model_edge();
    #1;
    chk("mode", mode, mode_of(m_st));
    chk("fan", fan_level, fan_of(m_st));
    chk("remain", remain_sec, m_rem);
    chk("tick", sec_tick, (m_cyc % CK == 0));
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc1();
  endtask

  task automatic press(input logic [5:0] mask);
    b = b | mask;
    cyc1();
    b = b & ~mask;
  endtask

  task automatic hold(input logic [5:0] mask, input int n);
    b = b | mask;
    run(n);
    b = b & ~mask;
    cyc1();
  endtask

  task automatic power_off();
`ifdef HOOD_LONG_PRESS_EN
    hold(6'b000001, 35);
`else
    press(6'b000001);
    cyc1();
`endif
  endtask

  task automatic wait_rem(input int v);
    for (int i = 0; i < 2000 && m_rem != v; i++) cyc1();
    chk("wait_remain", remain_sec, v);
  endtask

  initial begin
    rst = 1'b1;
    b = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_mode", mode, 0);
    chk("rst_fan", fan_level, 0);
    chk("rst_remain", remain_sec, 0);
    chk("rst_tick", sec_tick, 0);
    rst = 1'b0;
    run(3);

    // 1: power on, hurricane, expiry into level 2
    press(6'b000001); cyc1();
    chk("t1_select", mode, 1);
    press(6'b100000);
    chk("t1_mode", mode, 2);
    chk("t1_fan", fan_level, 3);
    chk("t1_remain", remain_sec, 60);
    run(605);
    chk("t1_fan_after", fan_level, 2);
    chk("t1_rem_after", remain_sec, 0);

    // 2: hurricane blocked until a new session
    press(6'b100000); cyc1();
    chk("t2_blocked_fan", fan_level, 2);
    power_off();
    chk("t2_off", mode, 0);
    press(6'b000001); cyc1();
    chk("t2_on", mode, 1);
    press(6'b100000);
    chk("t2_hurr_fan", fan_level, 3);

    // 3: menu during hurricane goes to exit wait
    wait_rem(40);
    press(6'b000010);
    chk("t3_mode", mode, 2);
    chk("t3_fan", fan_level, 0);
    chk("t3_remain", remain_sec, 60);
    press(6'b001000); cyc1();
    chk("t3_lvl_ignored", fan_level, 0);
    run(605);
    chk("t3_select", mode, 1);

    // 4: self-clean, menu ignored, expiry, then power during countdown
    press(6'b000100);
    chk("t4_mode", mode, 3);
    chk("t4_remain", remain_sec, 180);
    press(6'b000010); cyc1();
    chk("t4_menu_ignored", mode, 3);
    run(1805);
    chk("t4_done", mode, 1);
    press(6'b000100);
    wait_rem(5);
    power_off();
    chk("t4_off", mode, 0);
    chk("t4_off_rem", remain_sec, 0);
    press(6'b000001); cyc1();

    // 5: simultaneous power and level-1 edges in select
    press(6'b001001); cyc1();
`ifdef HOOD_LONG_PRESS_EN
    chk("t5_run1", mode, 2);
    chk("t5_fan1", fan_level, 1);
    hold(6'b000001, 35);
    chk("t5_long_off", mode, 0);
    press(6'b000001); cyc1();
    press(6'b001000); cyc1();
    hold(6'b000001, 20);
    chk("t5_short_hold", mode, 2);
    chk("t5_short_fan", fan_level, 1);
    power_off();
`else
    chk("t5_off", mode, 0);
    chk("t5_fan", fan_level, 0);
`endif
    press(6'b000001); cyc1();

    // 6: async reset in the middle of self-clean
    press(6'b000100);
    wait_rem(90);
    #2 rst = 1'b1;
    #1;
    chk("t6_mode", mode, 0);
    chk("t6_fan", fan_level, 0);
    chk("t6_remain", remain_sec, 0);
    chk("t6_tick", sec_tick, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
    run(30);
    chk("t6_stays_off", mode, 0);

    // Random traffic: dense presses, then sparse power so timed states can run out
    for (int i = 0; i < 800; i++) begin
      for (int k = 0; k < 6; k++) b[k] = ($urandom_range(7) == 0);
      cyc1();
    end
    for (int i = 0; i < 3000; i++) begin
      b[0] = ($urandom_range(299) == 0);
      for (int k = 1; k < 6; k++) b[k] = ($urandom_range(39) == 0);
      cyc1();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
